// File: rtl/mem_stage.sv
// Memory-access pipeline stage: captures SRAM load data, aligns/extends it, selects the
// final result, resolves branches and hands the instruction to writeback.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 123,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder,
    output logic [31:0]                ms_to_es_bus,
    output logic [6:0]                 ms_to_fw_bus,
    output logic                       br_taken,
    output logic [31:0]                br_target
);

    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q;
    logic [31:0]                rdata_hold_q;
    logic                       rdata_held_q;
    logic                       ms_ready_go;

    logic [1:0]  div_op;
    logic [31:0] ms_br_target;
    logic [8:0]  branch_op;
    logic        flag_c, flag_s, flag_o, flag_z;
    logic [4:0]  load_op;
    logic        mem_to_reg;
    logic        reg_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {div_op, ms_br_target, branch_op, flag_c, flag_s, flag_o, flag_z,
            load_op, mem_to_reg, reg_we, dest, alu_result, pc} = ms_bus_q;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            ms_bus_q     <= '0;
            rdata_hold_q <= '0;
            rdata_held_q <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                ms_bus_q     <= es_to_ms_bus;
                rdata_held_q <= 1'b0;
            end else if (ms_valid_q && !rdata_held_q) begin
                // SRAM data is only valid for one cycle; keep it for the whole stall
                rdata_hold_q <= data_sram_rdata;
                rdata_held_q <= 1'b1;
            end
        end
    end

    logic [31:0] rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    always_comb begin
        rdata = rdata_held_q ? rdata_hold_q : data_sram_rdata;
        unique case (alu_result[1:0])
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = alu_result[1] ? rdata[31:16] : rdata[15:0];

        load_result = '0;
        if (load_op[0]) begin
            load_result = {{24{ld_byte[7]}}, ld_byte};
        end else if (load_op[1]) begin
            load_result = {{16{ld_half[15]}}, ld_half};
        end else if (load_op[2]) begin
            load_result = rdata;
        end else if (load_op[3]) begin
            load_result = {24'b0, ld_byte};
        end else if (load_op[4]) begin
            load_result = {16'b0, ld_half};
        end

        if (mem_to_reg) begin
            final_result = load_result;
        end else if (div_op[0]) begin
            final_result = div_quotient;
        end else if (div_op[1]) begin
            final_result = div_remainder;
        end else begin
            final_result = alu_result;
        end
    end

    logic br_cond;
    logic lt_signed;

    // Flags come from src1 - src2; Carry is the borrow, i.e. unsigned less-than
    always_comb begin
        lt_signed = flag_s ^ flag_o;
        br_cond   = (branch_op[0] &&  flag_z)
                 || (branch_op[1] && !flag_z)
                 || (branch_op[2] &&  lt_signed)
                 || (branch_op[3] && !lt_signed)
                 || (branch_op[4] &&  flag_c)
                 || (branch_op[5] && !flag_c)
                 || (|branch_op[8:6]);
    end

    assign br_taken     = ms_valid_q && ws_allowin && br_cond;
    assign br_target    = ms_valid_q ? ms_br_target : 32'b0;
    assign ms_to_ws_bus = {reg_we, dest, final_result, pc};
    assign ms_to_es_bus = final_result;
    assign ms_to_fw_bus = {dest, reg_we && ms_valid_q, mem_to_reg && ms_valid_q};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal checks plus randomized traffic compared every
// cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [122:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic [31:0]  data_sram_rdata;
    logic [31:0]  div_quotient;
    logic [31:0]  div_remainder;
    logic [31:0]  ms_to_es_bus;
    logic [6:0]   ms_to_fw_bus;
    logic         br_taken;
    logic [31:0]  br_target;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .ms_to_es_bus    (ms_to_es_bus),
        .ms_to_fw_bus    (ms_to_fw_bus),
        .br_taken        (br_taken),
        .br_target       (br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [122:0] mk_bus(
        input logic [1:0] dop, input logic [31:0] tgt, input logic [8:0] bop,
        input logic c, input logic s, input logic o, input logic z,
        input logic [4:0] lop, input logic m2r, input logic we, input logic [4:0] dst,
        input logic [31:0] alu, input logic [31:0] pcv);
        return {dop, tgt, bop, c, s, o, z, lop, m2r, we, dst, alu, pcv};
    endfunction

    function automatic logic [31:0] load_val(input logic [4:0] lop, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [7:0]  by;
        logic [15:0] hw;
        by = 8'((rd >> (8 * addr[1:0])) & 32'hFF);
        hw = 16'(rd >> (16 * addr[1]));
        if (lop[0]) return {{24{by[7]}}, by};
        if (lop[1]) return {{16{hw[15]}}, hw};
        if (lop[2]) return rd;
        if (lop[3]) return {24'b0, by};
        if (lop[4]) return {16'b0, hw};
        return 32'b0;
    endfunction

    function automatic logic br_cond(input logic [122:0] b);
        logic [8:0] op;
        logic c, s, o, z;
        op = b[88:80];
        c = b[79]; s = b[78]; o = b[77]; z = b[76];
        return (op[0] && z) || (op[1] && !z) || (op[2] && (s != o)) || (op[3] && (s == o))
            || (op[4] && c) || (op[5] && !c) || op[6] || op[7] || op[8];
    endfunction

    // Reference model: which instruction occupies the stage and its captured load data
    logic         m_valid;
    logic [122:0] m_bus;
    logic         m_first;
    logic [31:0]  m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
        end else begin
            if (m_valid && m_first) begin
                m_rdata <= data_sram_rdata;
                m_first <= 1'b0;
            end
            if (!m_valid || ws_allowin) begin
                m_valid <= es_to_ms_valid;
                if (es_to_ms_valid) begin
                    m_bus   <= es_to_ms_bus;
                    m_first <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] rd;
        logic [31:0] fin;
        if (reset) begin
            chk("rst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
            chk("rst_br_taken", 70'(br_taken), 70'(0));
            chk("rst_fw_bus", 70'(ms_to_fw_bus), 70'(0));
            chk("rst_allowin", 70'(ms_allowin), 70'(1));
        end else begin
            chk("allowin", 70'(ms_allowin), 70'(!m_valid || ws_allowin));
            chk("ws_valid", 70'(ms_to_ws_valid), 70'(m_valid));
            if (m_valid) begin
                rd  = m_first ? data_sram_rdata : m_rdata;
                if (m_bus[70])       fin = load_val(m_bus[75:71], m_bus[63:32], rd);
                else if (m_bus[121]) fin = div_quotient;
                else if (m_bus[122]) fin = div_remainder;
                else                 fin = m_bus[63:32];
                chk("ws_bus", 70'(ms_to_ws_bus), {m_bus[69], m_bus[68:64], fin, m_bus[31:0]});
                chk("es_fwd", 70'(ms_to_es_bus), 70'(fin));
                chk("fw_bus", 70'(ms_to_fw_bus), 70'({m_bus[68:64], m_bus[69], m_bus[70]}));
                chk("br_taken", 70'(br_taken), 70'(ws_allowin && br_cond(m_bus)));
                chk("br_target", 70'(br_target), 70'(m_bus[120:89]));
            end else begin
                chk("idle_br_taken", 70'(br_taken), 70'(0));
                chk("idle_fw_flags", 70'(ms_to_fw_bus[1:0]), 70'(0));
            end
        end
    end

    // Offer b for one cycle, then drive the SRAM response for its first stage cycle
    task automatic enter(input logic [122:0] b, input logic [31:0] sram);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        @(posedge clk); #1;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = sram;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        div_quotient    = 32'd3;
        div_remainder   = 32'd7;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ld.b / ld.bu on byte 3
        enter(mk_bus(2'b00, 0, 9'b0, 0, 0, 0, 0, 5'b00001, 1, 1, 5'd3, 32'h1003, 32'h1C00_0000),
              32'h80FF_1234);
        #2 chk("ldb_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_FF80));
        chk("ldb_fw_load", 70'(ms_to_fw_bus), 70'({5'd3, 1'b1, 1'b1}));
        enter(mk_bus(2'b00, 0, 9'b0, 0, 0, 0, 0, 5'b01000, 1, 1, 5'd3, 32'h1003, 32'h1C00_0004),
              32'h80FF_1234);
        #2 chk("ldbu_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000_0080));

        // ld.h with a writeback stall while SRAM data changes
        enter(mk_bus(2'b00, 0, 9'b0, 0, 0, 0, 0, 5'b00010, 1, 1, 5'd4, 32'h2002, 32'h1C00_0008),
              32'h8001_7FFF);
        ws_allowin = 1'b0;
        #2 chk("ldh_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_8001));
        for (int i = 0; i < 2; i++) begin
            step();
            data_sram_rdata = 32'h0;
            #2 chk("ldh_stall_valid", 70'(ms_to_ws_valid), 70'(1));
            chk("ldh_stall_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_8001));
        end
        step();
        ws_allowin = 1'b1;
        #2 chk("ldh_release_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_8001));
        step();
        #2 chk("ldh_after_valid", 70'(ms_to_ws_valid), 70'(0));

        // blt taken, released after a two-cycle stall
        enter(mk_bus(2'b00, 32'h1C00_0040, 9'b000000100, 0, 1, 0, 0, 5'b0, 0, 0, 5'd0,
                     32'h0, 32'h1C00_0010), 32'h0);
        ws_allowin = 1'b0;
        #2 chk("blt_stall0", 70'(br_taken), 70'(0));
        step();
        #2 chk("blt_stall1", 70'(br_taken), 70'(0));
        step();
        ws_allowin = 1'b1;
        #2 chk("blt_taken", 70'(br_taken), 70'(1));
        chk("blt_target", 70'(br_target), 70'(32'h1C00_0040));
        step();
        #2 chk("blt_once", 70'(br_taken), 70'(0));

        // bgeu with borrow: never taken
        enter(mk_bus(2'b00, 32'h1C00_0080, 9'b000100000, 1, 0, 0, 0, 5'b0, 0, 0, 5'd0,
                     32'h0, 32'h1C00_0014), 32'h0);
        #2 chk("bgeu_not_taken", 70'(br_taken), 70'(0));

        // Divider result selection
        enter(mk_bus(2'b10, 0, 9'b0, 0, 0, 0, 0, 5'b0, 0, 1, 5'd6, 32'h55, 32'h1C00_0018), 32'h0);
        #2 chk("div_rem", 70'(ms_to_ws_bus[63:32]), 70'(32'd7));
        chk("div_rem_fwd", 70'(ms_to_es_bus), 70'(32'd7));
        enter(mk_bus(2'b01, 0, 9'b0, 0, 0, 0, 0, 5'b0, 0, 1, 5'd6, 32'h55, 32'h1C00_001C), 32'h0);
        #2 chk("div_quo", 70'(ms_to_es_bus), 70'(32'd3));

        // Back-to-back flow
        for (int i = 0; i < 6; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk_bus(2'b00, 0, 9'b0, 0, 0, 0, 0, 5'b0, 0, 1, 5'd1, 32'(i),
                                  32'h200 + 32'(4 * i));
            step();
            #2 chk("b2b_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h200 + 32'(4 * i)));
            chk("b2b_allowin", 70'(ms_allowin), 70'(1));
        end
        es_to_ms_valid = 1'b0;
        step();

        // Asynchronous reset while a taken bne sits in the stage
        enter(mk_bus(2'b00, 32'h1C00_0100, 9'b000000010, 0, 0, 0, 0, 5'b0, 0, 1, 5'd5,
                     32'h0, 32'h1C00_0020), 32'h0);
        ws_allowin = 1'b0;
        #1 chk("bne_stall_fw", 70'(ms_to_fw_bus), 70'({5'd5, 1'b1, 1'b0}));
        ws_allowin = 1'b1;
        #1 chk("bne_taken", 70'(br_taken), 70'(1));
        reset = 1'b1;
        #1 chk("async_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("async_br_taken", 70'(br_taken), 70'(0));
        chk("async_fw_bus", 70'(ms_to_fw_bus), 70'(0));
        #2 reset = 1'b0;

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            int k;
            logic [8:0] bop;
            logic [4:0] lop;
            step();
            k   = int'($urandom_range(0, 9));
            bop = (k == 9) ? 9'b0 : 9'(1 << k);
            lop = 5'(1 << $urandom_range(0, 4));
            es_to_ms_valid  = ($urandom_range(0, 9) < 7);
            ws_allowin      = ($urandom_range(0, 9) < 7);
            data_sram_rdata = $urandom;
            div_quotient    = $urandom;
            div_remainder   = $urandom;
            es_to_ms_bus = mk_bus(2'($urandom), $urandom, bop, 1'($urandom), 1'($urandom),
                                  1'($urandom), 1'($urandom), lop, 1'($urandom), 1'($urandom),
                                  5'($urandom), $urandom, $urandom);
        end
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
